// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence/run detector.
//   mode_e  : pattern matching mode (run = repeats tolerated, exact = one sample per element)
//   prog_w  : width needed to hold a progress value in 0..len
package seq_det_pkg;

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_EXACT = 1'b1
    } mode_e;

    function automatic int unsigned prog_w(input int unsigned len);
        return (len + 1 <= 2) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_pat_cfg.sv
// Pattern/mode configuration register with write validation.
//   clk, reset   : clock, asynchronous active-high reset
//   cfg_we       : request to load cfg_pattern/cfg_mode
//   cfg_pattern  : LEN elements of SYM_W bits, element i at [i*SYM_W +: SYM_W]
//   cfg_mode     : requested mode (mode_e encoding)
//   pattern/mode : currently active configuration
//   cfg_ok       : the request this cycle is accepted (combinational)
//   cfg_err      : last request was rejected, sticky until the next request
module seq_pat_cfg
    import seq_det_pkg::*;
#(
    parameter int unsigned            SYM_W     = 2,
    parameter int unsigned            LEN       = 3,
    parameter logic [LEN*SYM_W-1:0]   PAT_INIT  = 6'b111001,
    parameter logic                   MODE_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [LEN*SYM_W-1:0] cfg_pattern,
    input  logic                 cfg_mode,
    output logic [LEN*SYM_W-1:0] pattern,
    output mode_e                mode,
    output logic                 cfg_ok,
    output logic                 cfg_err
);

    logic [LEN*SYM_W-1:0] pattern_q, pattern_d;
    mode_e                mode_q, mode_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 adj_eq;

    // A run-mode pattern with two equal neighbours can never advance past the
    // first of them (the repeat rule wins), so it is refused.
    always_comb begin
        adj_eq = 1'b0;
        for (int unsigned i = 0; i + 1 < LEN; i++) begin
            if (cfg_pattern[i*SYM_W +: SYM_W] == cfg_pattern[(i+1)*SYM_W +: SYM_W]) begin
                adj_eq = 1'b1;
            end
        end
        cfg_ok = cfg_we && !((mode_e'(cfg_mode) == MODE_RUN) && adj_eq);
    end

    always_comb begin
        pattern_d = pattern_q;
        mode_d    = mode_q;
        cfg_err_d = cfg_err_q;
        if (cfg_we) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                mode_d    = mode_e'(cfg_mode);
                cfg_err_d = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= PAT_INIT;
            mode_q    <= mode_e'(MODE_INIT);
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign pattern = pattern_q;
    assign mode    = mode_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/seq_run_detector.sv
// Programmable run/sequence detector.
//   clk, reset   : clock, asynchronous active-high reset
//   en, num      : symbol stream (num valid when en=1)
//   cfg_we, cfg_pattern, cfg_mode : configuration write (takes priority over en)
//   ans          : progress has reached LEN
//   match_pulse  : one-cycle pulse when progress enters LEN
//   match_cnt    : saturating count of match_pulse events
//   progress     : number of pattern elements currently matched
//   cfg_err      : last configuration write was rejected
module seq_run_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned            SYM_W     = 2,
    parameter int unsigned            LEN       = 3,
    parameter int unsigned            CNT_W     = 8,
    parameter logic [LEN*SYM_W-1:0]   PAT_INIT  = 6'b111001,
    parameter logic                   MODE_INIT = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [SYM_W-1:0]           num,
    input  logic                       cfg_we,
    input  logic [LEN*SYM_W-1:0]       cfg_pattern,
    input  logic                       cfg_mode,
    output logic                       ans,
    output logic                       match_pulse,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [prog_w(LEN)-1:0]     progress,
    output logic                       cfg_err
);

    localparam int unsigned    PW     = prog_w(LEN);
    localparam logic [PW-1:0]  P_FULL = PW'(LEN);

    logic [LEN*SYM_W-1:0] pattern;
    mode_e                mode;
    logic                 cfg_ok;

    logic [PW-1:0]    p_q, p_d, p_step;
    logic             match_pulse_q, match_pulse_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [SYM_W-1:0] sym_cur, sym_prev;
    logic             hit_prev, hit_cur, hit_first;

    seq_pat_cfg #(
        .SYM_W     (SYM_W),
        .LEN       (LEN),
        .PAT_INIT  (PAT_INIT),
        .MODE_INIT (MODE_INIT)
    ) u_pat_cfg (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_mode    (cfg_mode),
        .pattern     (pattern),
        .mode        (mode),
        .cfg_ok      (cfg_ok),
        .cfg_err     (cfg_err)
    );

    // Next-element (pat[p]) and last-matched-element (pat[p-1]) selection.
    always_comb begin
        sym_cur  = '0;
        sym_prev = '0;
        for (int unsigned i = 0; i < LEN; i++) begin
            if (p_q == PW'(i))     sym_cur  = pattern[i*SYM_W +: SYM_W];
            if (p_q == PW'(i + 1)) sym_prev = pattern[i*SYM_W +: SYM_W];
        end
        hit_prev  = (p_q != '0) && (num == sym_prev);
        hit_cur   = (p_q != P_FULL) && (num == sym_cur);
        hit_first = (num == pattern[SYM_W-1:0]);

        if (mode == MODE_RUN && hit_prev) p_step = p_q;
        else if (hit_cur)                 p_step = p_q + PW'(1);
        else if (hit_first)               p_step = PW'(1);
        else                              p_step = '0;
    end

    always_comb begin
        p_d           = p_q;
        match_pulse_d = 1'b0;
        match_cnt_d   = match_cnt_q;
        if (cfg_ok) begin
            p_d         = '0;
            match_cnt_d = '0;
        end else if (en && !cfg_we) begin
            p_d = p_step;
            // In exact mode, staying at LEN is only reachable via a fresh
            // restart on pat[0] (LEN==1), which is a new match and pulses.
            match_pulse_d = (p_step == P_FULL) && ((p_q != P_FULL) || (mode == MODE_EXACT));
            if (match_pulse_d && (match_cnt_q != '1)) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q           <= '0;
            match_pulse_q <= 1'b0;
            match_cnt_q   <= '0;
        end else begin
            p_q           <= p_d;
            match_pulse_q <= match_pulse_d;
            match_cnt_q   <= match_cnt_d;
        end
    end

    assign ans         = (p_q == P_FULL);
    assign match_pulse = match_pulse_q;
    assign match_cnt   = match_cnt_q;
    assign progress    = p_q;

endmodule

// File: tb/tb_seq_run_detector.sv
module tb_seq_run_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] num = '0;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_pattern = '0;
    logic       cfg_mode = 1'b0;

    logic       ans, match_pulse, cfg_err;
    logic [7:0] match_cnt;
    logic [1:0] progress;

    logic       ans_c2, match_pulse_c2, cfg_err_c2;
    logic [1:0] match_cnt_c2;
    logic [1:0] progress_c2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_run_detector u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .num         (num),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_mode    (cfg_mode),
        .ans         (ans),
        .match_pulse (match_pulse),
        .match_cnt   (match_cnt),
        .progress    (progress),
        .cfg_err     (cfg_err)
    );

    seq_run_detector #(.CNT_W(2)) u_dut_c2 (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .num         (num),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_mode    (cfg_mode),
        .ans         (ans_c2),
        .match_pulse (match_pulse_c2),
        .match_cnt   (match_cnt_c2),
        .progress    (progress_c2),
        .cfg_err     (cfg_err_c2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step(input logic e, input logic [1:0] x);
        @(negedge clk);
        en = e; num = x; cfg_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [5:0] pat, input logic m, input logic e, input logic [1:0] x);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_mode = m; en = e; num = x;
        @(posedge clk);
        #1;
        cfg_we = 1'b0; en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Test 1 vectors: run mode, default pattern 1,2,3
    logic [1:0] t1_sym [10] = '{1, 1, 2, 2, 3, 3, 2, 1, 2, 3};
    int         t1_p   [10] = '{1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    int         t1_ans [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    int         t1_pls [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    // Test 2 vectors: exact mode, pattern 1,1,2
    logic [1:0] t2_sym [7]  = '{1, 1, 1, 2, 1, 1, 2};
    int         t2_p   [7]  = '{1, 2, 1, 0, 1, 2, 3};

    initial begin
        #12;
        check("rst_progress", 32'(progress), 0);
        check("rst_ans", 32'(ans), 0);
        check("rst_pulse", 32'(match_pulse), 0);
        check("rst_cnt", 32'(match_cnt), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: run mode with repeats
        for (int i = 0; i < 10; i++) begin
            step(1'b1, t1_sym[i]);
            check($sformatf("t1_p[%0d]", i), 32'(progress), 32'(t1_p[i]));
            check($sformatf("t1_ans[%0d]", i), 32'(ans), 32'(t1_ans[i]));
            check($sformatf("t1_pulse[%0d]", i), 32'(match_pulse), 32'(t1_pls[i]));
        end
        check("t1_cnt", 32'(match_cnt), 2);

        // 2: exact mode, pattern 1,1,2 (adjacent-equal allowed in exact mode)
        cfg(6'b10_01_01, 1'b1, 1'b0, 2'd0);
        check("t2_cfg_err", 32'(cfg_err), 0);
        check("t2_cfg_p", 32'(progress), 0);
        check("t2_cfg_cnt", 32'(match_cnt), 0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, t2_sym[i]);
            check($sformatf("t2_p[%0d]", i), 32'(progress), 32'(t2_p[i]));
        end
        check("t2_ans", 32'(ans), 1);
        check("t2_cnt", 32'(match_cnt), 1);

        // 3: en gating, run mode pattern 1,2,3
        cfg(6'b11_10_01, 1'b0, 1'b0, 2'd0);
        step(1'b1, 2'd1);
        step(1'b1, 2'd2);
        check("t3_p_pre", 32'(progress), 2);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'd3);
            check($sformatf("t3_hold_p[%0d]", i), 32'(progress), 2);
            check($sformatf("t3_hold_pulse[%0d]", i), 32'(match_pulse), 0);
        end
        step(1'b1, 2'd3);
        check("t3_ans", 32'(ans), 1);
        check("t3_pulse", 32'(match_pulse), 1);
        step(1'b0, 2'd3);
        check("t3_pulse_drop", 32'(match_pulse), 0);
        check("t3_ans_hold", 32'(ans), 1);

        // 4: saturation on the CNT_W=2 instance, exact mode 1,2,3
        do_reset();
        cfg(6'b11_10_01, 1'b1, 1'b0, 2'd0);
        for (int m = 0; m < 5; m++) begin
            step(1'b1, 2'd1);
            step(1'b1, 2'd2);
            step(1'b1, 2'd3);
            check($sformatf("t4_cnt2[%0d]", m), 32'(match_cnt_c2), (m < 3) ? m + 1 : 3);
            check($sformatf("t4_cnt8[%0d]", m), 32'(match_cnt), m + 1);
        end

        // 5: rejected run-mode cfg 1,1,3 leaves state alone
        cfg(6'b11_01_01, 1'b0, 1'b0, 2'd0);
        check("t5_cfg_err", 32'(cfg_err), 1);
        check("t5_p_kept", 32'(progress), 3);
        check("t5_cnt_kept", 32'(match_cnt), 5);
        step(1'b1, 2'd1);
        step(1'b1, 2'd2);
        step(1'b1, 2'd3);
        check("t5_old_pat_ans", 32'(ans), 1);
        check("t5_err_sticky", 32'(cfg_err), 1);
        // valid cfg 3,0,2 with a symbol that must be dropped
        cfg(6'b10_00_11, 1'b0, 1'b1, 2'd3);
        check("t5_drop_p", 32'(progress), 0);
        check("t5_err_clr", 32'(cfg_err), 0);
        check("t5_cnt_clr", 32'(match_cnt), 0);
        step(1'b1, 2'd3);
        step(1'b1, 2'd3);
        check("t5_new_rep", 32'(progress), 1);
        step(1'b1, 2'd0);
        step(1'b1, 2'd2);
        check("t5_new_ans", 32'(ans), 1);

        // 6: async reset mid-stream with p=2, cnt=4
        for (int m = 0; m < 3; m++) begin
            step(1'b1, 2'd3);
            step(1'b1, 2'd0);
            step(1'b1, 2'd2);
        end
        step(1'b1, 2'd3);
        step(1'b1, 2'd0);
        check("t6_pre_p", 32'(progress), 2);
        check("t6_pre_cnt", 32'(match_cnt), 4);
        cfg(6'b01_00_00, 1'b0, 1'b0, 2'd0);
        check("t6_pre_err", 32'(cfg_err), 1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_p", 32'(progress), 0);
        check("t6_rst_ans", 32'(ans), 0);
        check("t6_rst_cnt", 32'(match_cnt), 0);
        check("t6_rst_err", 32'(cfg_err), 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 2'd1);
        step(1'b1, 2'd1);
        check("t6_init_run", 32'(progress), 1);
        step(1'b1, 2'd2);
        step(1'b1, 2'd3);
        check("t6_init_ans", 32'(ans), 1);
        check("t6_init_cnt", 32'(match_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
